ofmap_writeback_ctrl: RTL and testbench

- Write-side counterpart to the conv read/MAC control path.
- Accepts one accumulator result per accum_sload-terminated pixel cycle, then quantizes it: round, shift, saturate, optional ReLU.
- Buffers results and writes them into output feature-map M9K memory over a valid/ready write port, generating the ofmap address.
- Flags completion after OUT_FEATURE_WIDTH_W*OUT_FEATURE_WIDTH_H*NUM_ONEMULT writes.

---
 rtl/ofmap_writeback_ctrl_pkg.sv | 23 ++
 rtl/ofmap_wb_fifo.sv | 51 +++++
 rtl/ofmap_writeback_ctrl.sv | 208 ++++++++++++++++++++
 tb/tb_ofmap_writeback_ctrl.sv | 321 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ofmap_writeback_ctrl_pkg.sv
// Shared types and frame constants for the ofmap write-back path.
// Module parameters default from these; each instance derives its own frame geometry.
package ofmap_writeback_ctrl_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_DRAIN = 2'd2,
        ST_DONE  = 2'd3
    } wb_state_t;

    localparam int OFMAP_TOTAL      = 24 * 24 * 2;
    localparam int OFMAP_MAP_STRIDE = 24 * 24;
    localparam int ACC_WIDTH        = 40;
    localparam int FRAC_SHIFT       = 8;
    localparam bit RELU_EN          = 1'b1;

    // Counter width that never collapses to zero bits for a range of one.
    function automatic int width_of(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/ofmap_wb_fifo.sv
// Result buffer between the quant stage and the ofmap write register.
// Entries are {addr, data}; push while full is legal only together with a pop.
module ofmap_wb_fifo #(
    parameter int DEPTH      = 4,
    parameter int ADDR_WIDTH = 11,
    parameter int DATA_WIDTH = 16
) (
    input  logic                             clock,
    input  logic                             reset,
    input  logic                             push,
    input  logic                             pop,
    input  logic [ADDR_WIDTH+DATA_WIDTH-1:0] wdata,
    output logic [ADDR_WIDTH+DATA_WIDTH-1:0] rdata,
    output logic                             full,
    output logic                             empty,
    output logic [$clog2(DEPTH):0]           count
);
    import ofmap_writeback_ctrl_pkg::*;

    localparam int PTR_W   = $clog2(DEPTH);
    localparam int ENTRY_W = ADDR_WIDTH + DATA_WIDTH;

    logic [ENTRY_W-1:0] mem [DEPTH];
    logic [PTR_W-1:0]   wr_ptr;
    logic [PTR_W-1:0]   rd_ptr;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge clock) begin
        if (push) mem[wr_ptr] <= wdata;
    end

    assign rdata = mem[rd_ptr];
    assign empty = (count == '0);
    assign full  = (count == (PTR_W+1)'(DEPTH));

endmodule

// File: rtl/ofmap_writeback_ctrl.sv
// Output feature-map write-back: quantize accumulator results, buffer them and
// write them to ofmap memory with generated addresses, flagging frame completion.
module ofmap_writeback_ctrl #(
    parameter int DATA_WIDTH          = 16,
    parameter int ACC_WIDTH           = ofmap_writeback_ctrl_pkg::ACC_WIDTH,
    parameter int FRAC_SHIFT          = ofmap_writeback_ctrl_pkg::FRAC_SHIFT,
    parameter int OUT_FEATURE_WIDTH_W = 24,
    parameter int OUT_FEATURE_WIDTH_H = 24,
    parameter int NUM_ONEMULT         = 2,
    parameter int ADDR_WIDTH          = 11,
    parameter bit RELU_EN             = ofmap_writeback_ctrl_pkg::RELU_EN,
    parameter int FIFO_DEPTH          = 4
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  start,
    input  logic                  acc_valid,
    input  logic [ACC_WIDTH-1:0]  acc_data,
    input  logic                  ofmap_wr_ready,
    output logic                  ofmap_wren,
    output logic [ADDR_WIDTH-1:0] ofmap_addr,
    output logic [DATA_WIDTH-1:0] ofmap_data,
    output logic                  wb_busy,
    output logic                  wb_done,
    output logic                  extra_err,
    output logic [1:0]            wb_state
);
    import ofmap_writeback_ctrl_pkg::*;

    // Write port handshake: ofmap_wren is a valid that, once raised, holds with
    // addr/data unchanged until the cycle ofmap_wr_ready is seen high; that cycle
    // the write completes and the next buffered result may load.

    localparam int FRAME_LEN  = OUT_FEATURE_WIDTH_W * OUT_FEATURE_WIDTH_H * NUM_ONEMULT;
    localparam int MAP_STRIDE = OUT_FEATURE_WIDTH_W * OUT_FEATURE_WIDTH_H;
    localparam int CNT_W      = width_of(FRAME_LEN + 1);
    localparam int MAP_W      = width_of(NUM_ONEMULT);
    localparam int COL_W      = width_of(OUT_FEATURE_WIDTH_W);
    localparam int ROW_W      = width_of(OUT_FEATURE_WIDTH_H);
    localparam int PTR_W      = $clog2(FIFO_DEPTH);
    localparam int OCC_W      = width_of(FIFO_DEPTH + 3);
    localparam int ENTRY_W    = ADDR_WIDTH + DATA_WIDTH;

    localparam logic signed [ACC_WIDTH:0] ROUND_BIAS = {{ACC_WIDTH{1'b0}}, 1'b1} << (FRAC_SHIFT - 1);
    localparam logic signed [ACC_WIDTH:0] SAT_MAX =
        {{(ACC_WIDTH + 2 - DATA_WIDTH){1'b0}}, {(DATA_WIDTH - 1){1'b1}}};
    localparam logic signed [ACC_WIDTH:0] SAT_MIN =
        {{(ACC_WIDTH + 2 - DATA_WIDTH){1'b1}}, {(DATA_WIDTH - 1){1'b0}}};

    wb_state_t state;
    wb_state_t state_nxt;

    logic                  start_q;
    logic                  start_rise;
    logic                  frame_start;
    logic [CNT_W-1:0]      in_cnt;
    logic [CNT_W-1:0]      wr_cnt;
    logic [MAP_W-1:0]      map_idx;
    logic [COL_W-1:0]      col;
    logic [ROW_W-1:0]      row;
    logic                  q_valid;
    logic [ADDR_WIDTH-1:0] q_addr;
    logic [DATA_WIDTH-1:0] q_data;
    logic                  fifo_push;
    logic                  fifo_pop;
    logic                  fifo_full;
    logic                  fifo_empty;
    logic [PTR_W:0]        fifo_count;
    logic [ENTRY_W-1:0]    fifo_head;
    logic                  write_fire;
    logic                  out_load;
    logic [OCC_W-1:0]      occupancy;
    logic                  room;
    logic                  accept;
    logic                  drop;
    logic                  last_in;
    logic                  last_wr;
    logic [ADDR_WIDTH-1:0] in_addr;
    logic signed [ACC_WIDTH:0] biased;
    logic signed [ACC_WIDTH:0] shifted;
    logic [DATA_WIDTH-1:0] quant;

    assign start_rise  = start && !start_q;
    assign frame_start = start_rise && ((state == ST_IDLE) || (state == ST_DONE));
    assign write_fire  = ofmap_wren && ofmap_wr_ready;
    assign out_load    = !ofmap_wren || write_fire;
    assign fifo_pop    = out_load && !fifo_empty;
    assign fifo_push   = q_valid && (!fifo_full || fifo_pop);

    // Every accepted result sits in exactly one of quant stage, FIFO or output register.
    assign occupancy = OCC_W'(fifo_count) + OCC_W'(q_valid) + OCC_W'(ofmap_wren);
    assign room      = (occupancy < OCC_W'(FIFO_DEPTH + 2)) || write_fire;
    assign accept    = acc_valid && (state == ST_RUN) && room;
    assign drop      = acc_valid && (state != ST_IDLE) && !accept;
    assign last_in   = (in_cnt == CNT_W'(FRAME_LEN - 1));
    assign last_wr   = (wr_cnt == CNT_W'(FRAME_LEN - 1));

    assign in_addr = ADDR_WIDTH'(int'(map_idx) * MAP_STRIDE
                                + int'(row) * OUT_FEATURE_WIDTH_W + int'(col));

    always_comb begin
        biased  = {acc_data[ACC_WIDTH-1], acc_data} + ROUND_BIAS;
        shifted = biased >>> FRAC_SHIFT;
        quant   = shifted[DATA_WIDTH-1:0];
        if (RELU_EN && shifted[ACC_WIDTH]) quant = '0;
        else if (shifted > SAT_MAX)        quant = SAT_MAX[DATA_WIDTH-1:0];
        else if (shifted < SAT_MIN)        quant = SAT_MIN[DATA_WIDTH-1:0];
    end

    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE:  if (frame_start)           state_nxt = ST_RUN;
            ST_RUN:   if (accept && last_in)     state_nxt = ST_DRAIN;
            ST_DRAIN: if (write_fire && last_wr) state_nxt = ST_DONE;
            ST_DONE:  if (frame_start)           state_nxt = ST_RUN;
            default:                             state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) state <= ST_IDLE;
        else        state <= state_nxt;
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            start_q    <= 1'b0;
            in_cnt     <= '0;
            wr_cnt     <= '0;
            map_idx    <= '0;
            col        <= '0;
            row        <= '0;
            q_valid    <= 1'b0;
            q_addr     <= '0;
            q_data     <= '0;
            ofmap_wren <= 1'b0;
            ofmap_addr <= '0;
            ofmap_data <= '0;
            extra_err  <= 1'b0;
        end else begin
            start_q <= start;

            if (frame_start) begin
                in_cnt  <= '0;
                wr_cnt  <= '0;
                map_idx <= '0;
                col     <= '0;
                row     <= '0;
            end else begin
                if (write_fire) wr_cnt <= wr_cnt + 1'b1;
                if (accept) begin
                    in_cnt <= in_cnt + 1'b1;
                    // Map index is the fastest-moving, then column, then row.
                    if (map_idx == MAP_W'(NUM_ONEMULT - 1)) begin
                        map_idx <= '0;
                        if (col == COL_W'(OUT_FEATURE_WIDTH_W - 1)) begin
                            col <= '0;
                            if (row == ROW_W'(OUT_FEATURE_WIDTH_H - 1)) row <= '0;
                            else                                          row <= row + 1'b1;
                        end else begin
                            col <= col + 1'b1;
                        end
                    end else begin
                        map_idx <= map_idx + 1'b1;
                    end
                end
            end

            if (accept) begin
                q_valid <= 1'b1;
                q_addr  <= in_addr;
                q_data  <= quant;
            end else if (fifo_push) begin
                q_valid <= 1'b0;
            end

            if (out_load) begin
                ofmap_wren <= !fifo_empty;
                if (!fifo_empty) {ofmap_addr, ofmap_data} <= fifo_head;
            end

            if (frame_start) extra_err <= 1'b0;
            else if (drop)   extra_err <= 1'b1;
        end
    end

    ofmap_wb_fifo #(
        .DEPTH      (FIFO_DEPTH),
        .ADDR_WIDTH (ADDR_WIDTH),
        .DATA_WIDTH (DATA_WIDTH)
    ) u_fifo (
        .clock (clock),
        .reset (reset),
        .push  (fifo_push),
        .pop   (fifo_pop),
        .wdata ({q_addr, q_data}),
        .rdata (fifo_head),
        .full  (fifo_full),
        .empty (fifo_empty),
        .count (fifo_count)
    );

    assign wb_busy  = (state == ST_RUN) || (state == ST_DRAIN);
    assign wb_done  = (state == ST_DONE);
    assign wb_state = state;

endmodule

// File: tb/tb_ofmap_writeback_ctrl.sv
// Randomized bench for ofmap_writeback_ctrl on a 2x2x2 frame, scored against a
// transaction-level model of quantization, addressing, buffering and frame flags.
module tb_ofmap_writeback_ctrl;

    localparam int W      = 2;
    localparam int H      = 2;
    localparam int NM     = 2;
    localparam int DW     = 16;
    localparam int AW     = 11;
    localparam int ACC_W  = 40;
    localparam int FS     = 8;
    localparam int DEPTH  = 4;
    localparam bit RELU   = 1'b1;
    localparam int TOTAL  = W * H * NM;
    localparam int MAXOCC = DEPTH + 2;

    logic             clock = 1'b0;
    logic             reset;
    logic             start;
    logic             acc_valid;
    logic [ACC_W-1:0] acc_data;
    logic             ofmap_wr_ready;
    logic             ofmap_wren;
    logic [AW-1:0]    ofmap_addr;
    logic [DW-1:0]    ofmap_data;
    logic             wb_busy;
    logic             wb_done;
    logic             extra_err;
    logic [1:0]       wb_state;

    ofmap_writeback_ctrl #(
        .DATA_WIDTH          (DW),
        .ACC_WIDTH           (ACC_W),
        .FRAC_SHIFT          (FS),
        .OUT_FEATURE_WIDTH_W (W),
        .OUT_FEATURE_WIDTH_H (H),
        .NUM_ONEMULT         (NM),
        .ADDR_WIDTH          (AW),
        .RELU_EN             (RELU),
        .FIFO_DEPTH          (DEPTH)
    ) dut (
        .clock          (clock),
        .reset          (reset),
        .start          (start),
        .acc_valid      (acc_valid),
        .acc_data       (acc_data),
        .ofmap_wr_ready (ofmap_wr_ready),
        .ofmap_wren     (ofmap_wren),
        .ofmap_addr     (ofmap_addr),
        .ofmap_data     (ofmap_data),
        .wb_busy        (wb_busy),
        .wb_done        (wb_done),
        .extra_err      (extra_err),
        .wb_state       (wb_state)
    );

    always #5 clock = ~clock;

    int n_vec = 0;
    int n_err = 0;

    logic [AW+DW-1:0] exp_q[$];
    bit m_busy;
    bit m_done;
    bit m_err;
    bit m_start_prev;
    int m_acc;
    int m_wr;
    bit rand_ready;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Round-half-up shift, clamp to the signed word range, then ReLU.
    function automatic logic [DW-1:0] model_quant(input logic [ACC_W-1:0] raw);
        logic signed [ACC_W-1:0] s;
        longint v;
        longint lim;
        s   = raw;
        v   = s;
        lim = longint'(1) <<< (DW - 1);
        v   = (v + (longint'(1) <<< (FS - 1))) >>> FS;
        if (v > lim - 1) v = lim - 1;
        if (v < -lim)    v = -lim;
        if (RELU && v < 0) v = 0;
        return DW'(v);
    endfunction

    // n-th accepted input of a frame: map = n mod NM, pixel = n div NM (raster order).
    function automatic logic [AW-1:0] model_addr(input int n);
        return AW'((n % NM) * W * H + n / NM);
    endfunction

    function automatic logic [ACC_W-1:0] rand_acc();
        logic [63:0] r;
        longint b;
        r = {$urandom, $urandom};
        case ($urandom_range(0, 2))
            0:       return r[ACC_W-1:0];
            1:       return ACC_W'(longint'($urandom_range(0, 1 << 25)) - (longint'(1) <<< 24));
            default: begin
                b = longint'($signed(r[15:0])) <<< FS;
                return ACC_W'(b + 127 + longint'(r[16]));
            end
        endcase
    endfunction

    task automatic model_reset();
        exp_q.delete();
        m_busy       = 1'b0;
        m_done       = 1'b0;
        m_err        = 1'b0;
        m_start_prev = 1'b0;
        m_acc        = 0;
        m_wr         = 0;
    endtask

    // Scoreboard: compare flags and the head write, then advance the model one edge.
    always @(negedge clock) begin
        bit fire;
        bit rise;
        bit old_busy;
        bit old_done;
        int sz;
        logic [AW+DW-1:0] e;
        if (reset) begin
            check("wb_busy", wb_busy, m_busy);
            check("wb_done", wb_done, m_done);
            check("extra_err", extra_err, m_err);
            if (ofmap_wren) begin
                if (exp_q.size() == 0) begin
                    check("wren_spurious", ofmap_wren, 1'b0);
                end else begin
                    e = exp_q[0];
                    check("wr_addr", ofmap_addr, e[AW+DW-1:DW]);
                    check("wr_data", ofmap_data, e[DW-1:0]);
                end
            end
            old_busy     = m_busy;
            old_done     = m_done;
            fire         = ofmap_wren && ofmap_wr_ready;
            sz           = exp_q.size();
            rise         = start && !m_start_prev;
            m_start_prev = start;
            if (fire && sz > 0) begin
                void'(exp_q.pop_front());
                m_wr++;
                if (m_wr == TOTAL) begin
                    m_busy = 1'b0;
                    m_done = 1'b1;
                end
            end
            if (acc_valid && (old_busy || old_done)) begin
                if (old_busy && m_acc < TOTAL && (sz < MAXOCC || fire)) begin
                    exp_q.push_back({model_addr(m_acc), model_quant(acc_data)});
                    m_acc++;
                end else begin
                    m_err = 1'b1;
                end
            end
            if (rise && !old_busy) begin
                m_busy = 1'b1;
                m_done = 1'b0;
                m_err  = 1'b0;
                m_acc  = 0;
                m_wr   = 0;
            end
        end
    end

    task automatic tick();
        @(posedge clock);
        #1;
        acc_valid = 1'b0;
        if (rand_ready) ofmap_wr_ready = ($urandom_range(0, 3) != 0);
    endtask

    task automatic pulse(input logic [ACC_W-1:0] d);
        acc_valid = 1'b1;
        acc_data  = d;
        tick();
    endtask

    task automatic start_frame();
        start = 1'b0;
        tick();
        start = 1'b1;
        tick();
    endtask

    task automatic wait_frame(input int budget);
        for (int i = 0; i < budget && !m_done; i++) tick();
        check("frame_done", m_done, 1'b1);
        check("queue_drained", exp_q.size(), 0);
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_wren"}, ofmap_wren, 1'b0);
        check({tag, "_addr"}, ofmap_addr, '0);
        check({tag, "_data"}, ofmap_data, '0);
        check({tag, "_busy"}, wb_busy, 1'b0);
        check({tag, "_done"}, wb_done, 1'b0);
        check({tag, "_err"}, extra_err, 1'b0);
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog: run did not complete in time");
        $fatal(1);
    end

    initial begin
        reset          = 1'b0;
        start          = 1'b0;
        acc_valid      = 1'b0;
        acc_data       = '0;
        ofmap_wr_ready = 1'b1;
        rand_ready     = 1'b0;
        model_reset();
        #3;
        check_reset_outputs("por");
        tick();
        tick();
        reset = 1'b1;
        tick();

        // Quantization corners, ready tied high, then one input past frame end.
        start_frame();
        pulse(ACC_W'(384));
        pulse(ACC_W'(-384));
        pulse(ACC_W'(longint'(1) <<< 30));
        for (int i = 0; i < TOTAL - 3; i++) pulse(rand_acc());
        wait_frame(50);
        tick();
        pulse(rand_acc());
        check("err_after_done", extra_err, 1'b1);
        tick();

        // Restart, then single-input latency with an empty pipeline.
        start_frame();
        repeat (3) tick();
        check("lat_idle", ofmap_wren, 1'b0);
        pulse(rand_acc());
        check("lat_k1", ofmap_wren, 1'b0);
        tick();
        check("lat_k2", ofmap_wren, 1'b0);
        tick();
        check("lat_k3", ofmap_wren, 1'b1);
        tick();
        check("lat_k4", ofmap_wren, 1'b0);
        for (int i = 0; i < TOTAL - 1; i++) pulse(rand_acc());
        wait_frame(50);

        // Backpressure: six inputs held behind ready=0 for 20 cycles.
        start_frame();
        ofmap_wr_ready = 1'b0;
        for (int i = 0; i < 6; i++) pulse(rand_acc());
        repeat (14) tick();
        check("bp_no_drop", extra_err, 1'b0);
        check("bp_held", m_acc, 6);
        ofmap_wr_ready = 1'b1;
        repeat (8) tick();
        pulse(rand_acc());
        pulse(rand_acc());
        wait_frame(50);

        // Overflow: seventh input with the pipeline full is dropped.
        start_frame();
        ofmap_wr_ready = 1'b0;
        for (int i = 0; i < 7; i++) pulse(rand_acc());
        check("ovf_err", extra_err, 1'b1);
        check("ovf_accepted", m_acc, 6);
        ofmap_wr_ready = 1'b1;
        repeat (4) tick();
        for (int i = 0; i < 10 && m_acc < TOTAL; i++) pulse(rand_acc());
        wait_frame(50);
        check("ovf_err_sticky", extra_err, 1'b1);

        // Reset mid-frame after three writes.
        start_frame();
        for (int i = 0; i < 40 && m_wr < 3; i++) pulse(rand_acc());
        check("mid_writes", m_wr, 3);
        reset     = 1'b0;
        start     = 1'b0;
        acc_valid = 1'b0;
        #1;
        check_reset_outputs("mid_rst");
        model_reset();
        tick();
        tick();
        reset = 1'b1;
        tick();
        start_frame();
        for (int i = 0; i < TOTAL; i++) pulse(rand_acc());
        wait_frame(50);

        // Random traffic: sparse inputs, random ready, extras during drain.
        rand_ready = 1'b1;
        for (int f = 0; f < 4; f++) begin
            start_frame();
            for (int i = 0; i < 400 && !m_done; i++) begin
                if ($urandom_range(0, 2) != 0) pulse(rand_acc());
                else tick();
            end
            check("rand_frame_done", m_done, 1'b1);
            tick();
        end
        rand_ready     = 1'b0;
        ofmap_wr_ready = 1'b1;
        repeat (3) tick();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
